// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI slave.
// Holds the FSM encoding, command codes and bit counts.
package spi_pkg;

   localparam int DATA_WIDTH_DEF = 10;
   localparam int RX_BITS        = 10;
   localparam int TX_BITS        = 8;

   localparam logic [1:0] WR_ADDR = 2'b00;
   localparam logic [1:0] WR_DATA = 2'b01;
   localparam logic [1:0] RD_ADDR = 2'b10;
   localparam logic [1:0] RD_DATA = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHK_CMD,
      ST_WRITE,
      ST_READ_ADD,
      ST_READ_DATA
   } state_t;

endpackage

// File: rtl/spi_shift_counter.sv
// Loadable down-counter that saturates at zero.
// tc flags the terminal count (counter at zero).
module spi_shift_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_val,
   output logic         tc
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (load) begin
         cnt_d = load_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc = (cnt_q == '0);

endmodule

// File: rtl/spi_slave.sv
// SPI slave: deserializes command/payload words from MOSI and
// serializes RAM read data back on MISO after a read-data command.
module spi_slave
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  MOSI,
   input  logic                  SS_n,
   input  logic                  tx_valid,
   input  logic [DATA_WIDTH-3:0] tx_data,
   output logic                  MISO,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid
);

   localparam int TXW = DATA_WIDTH - 2;
   localparam int CW  = $clog2(DATA_WIDTH);

   state_t                state_q, state_d;
   logic [DATA_WIDTH-2:0] rx_shift_q, rx_shift_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  rd_addr_flag_q, rd_addr_flag_d;
   logic                  done_q, done_d;
   logic                  pend_q, pend_d;
   logic                  active_q, active_d;
   logic [TXW-1:0]        tx_shift_q, tx_shift_d;
   logic                  miso_q, miso_d;

   logic rx_clr, rx_load, rx_en, rx_tc;
   logic tx_clr, tx_load, tx_en, tx_tc;

   spi_shift_counter #(.W(CW)) u_rx_cnt (
      .clk      (clk),
      .rst      (rst),
      .clr      (rx_clr),
      .load     (rx_load),
      .en       (rx_en),
      .load_val (CW'(DATA_WIDTH - 2)),
      .tc       (rx_tc)
   );

   spi_shift_counter #(.W(CW)) u_tx_cnt (
      .clk      (clk),
      .rst      (rst),
      .clr      (tx_clr),
      .load     (tx_load),
      .en       (tx_en),
      .load_val (CW'(TXW - 1)),
      .tc       (tx_tc)
   );

   always_comb begin
      state_d        = state_q;
      rx_shift_d     = rx_shift_q;
      rx_data_d      = rx_data_q;
      rx_valid_d     = 1'b0;
      rd_addr_flag_d = rd_addr_flag_q;
      done_d         = done_q;
      pend_d         = pend_q;
      active_d       = active_q;
      tx_shift_d     = tx_shift_q;
      miso_d         = miso_q;
      rx_clr         = 1'b0;
      rx_load        = 1'b0;
      rx_en          = 1'b0;
      tx_clr         = 1'b0;
      tx_load        = 1'b0;
      tx_en          = 1'b0;
      if (SS_n) begin
         state_d    = ST_IDLE;
         rx_shift_d = '0;
         tx_shift_d = '0;
         miso_d     = 1'b0;
         done_d     = 1'b0;
         pend_d     = 1'b0;
         active_d   = 1'b0;
         rx_clr     = 1'b1;
         tx_clr     = 1'b1;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               state_d = ST_CHK_CMD;
            end
            ST_CHK_CMD: begin
               rx_shift_d = {rx_shift_q[DATA_WIDTH-3:0], MOSI};
               rx_load    = 1'b1;
               if (!MOSI) begin
                  state_d = ST_WRITE;
               end else if (rd_addr_flag_q) begin
                  state_d = ST_READ_DATA;
               end else begin
                  state_d = ST_READ_ADD;
               end
            end
            default: begin
               // Once the word is in, further MOSI bits are ignored.
               if (!done_q) begin
                  rx_shift_d = {rx_shift_q[DATA_WIDTH-3:0], MOSI};
                  if (rx_tc) begin
                     rx_data_d  = {rx_shift_q, MOSI};
                     rx_valid_d = 1'b1;
                     done_d     = 1'b1;
                     if (state_q == ST_READ_ADD) begin
                        rd_addr_flag_d = 1'b1;
                     end
                     if (state_q == ST_READ_DATA) begin
                        pend_d = 1'b1;
                     end
                  end else begin
                     rx_en = 1'b1;
                  end
               end
            end
         endcase
         if (active_q) begin
            if (tx_tc) begin
               miso_d         = 1'b0;
               active_d       = 1'b0;
               rd_addr_flag_d = 1'b0;
            end else begin
               miso_d     = tx_shift_q[TXW-1];
               tx_shift_d = {tx_shift_q[TXW-2:0], 1'b0};
               tx_en      = 1'b1;
            end
         end else if (pend_q && tx_valid) begin
            tx_load    = 1'b1;
            miso_d     = tx_data[TXW-1];
            tx_shift_d = {tx_data[TXW-2:0], 1'b0};
            active_d   = 1'b1;
            pend_d     = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         rx_shift_q     <= '0;
         rx_data_q      <= '0;
         rx_valid_q     <= 1'b0;
         rd_addr_flag_q <= 1'b0;
         done_q         <= 1'b0;
         pend_q         <= 1'b0;
         active_q       <= 1'b0;
         tx_shift_q     <= '0;
         miso_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         rx_shift_q     <= rx_shift_d;
         rx_data_q      <= rx_data_d;
         rx_valid_q     <= rx_valid_d;
         rd_addr_flag_q <= rd_addr_flag_d;
         done_q         <= done_d;
         pend_q         <= pend_d;
         active_q       <= active_d;
         tx_shift_q     <= tx_shift_d;
         miso_q         <= miso_d;
      end
   end

   assign MISO     = miso_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;

endmodule
